// File: rtl/regfile_dump_pkg.sv
// Shared types and defaults for the register-file dump engine.
// State encoding, default geometry and the zero-register index.
package regfile_dump_pkg;

    localparam int unsigned DUMP_DW     = 64;
    localparam int unsigned DUMP_NREGS  = 32;
    localparam int unsigned DUMP_AW     = 5;
    localparam int unsigned DUMP_ZR_IDX = DUMP_NREGS - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND_LO,
        S_SEND_HI,
        S_DONE
    } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Walks every register pair through the two read ports, streams each word out
// over valid/ready with its index, and keeps an XOR checksum of accepted words.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int unsigned DW       = DUMP_DW,
    parameter int unsigned NREGS    = DUMP_NREGS,
    parameter int unsigned AW       = DUMP_AW,
    parameter bit          FORCE_ZR = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          hold_wr,
    output logic [AW-1:0] ra1,
    output logic [AW-1:0] ra2,
    input  logic [DW-1:0] rd1,
    input  logic [DW-1:0] rd2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_idx,
    output logic [DW-1:0] checksum
);

    localparam logic [AW-2:0] K_LAST = (AW-1)'(NREGS / 2 - 1);

    dump_state_t   state, state_nx;
    logic [AW-2:0] k, k_nx;
    logic [DW-1:0] buf_lo, buf_lo_nx;
    logic [DW-1:0] buf_hi, buf_hi_nx;
    logic [DW-1:0] csum, csum_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            k      <= '0;
            buf_lo <= '0;
            buf_hi <= '0;
            csum   <= '0;
        end else begin
            state  <= state_nx;
            k      <= k_nx;
            buf_lo <= buf_lo_nx;
            buf_hi <= buf_hi_nx;
            csum   <= csum_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        k_nx      = k;
        buf_lo_nx = buf_lo;
        buf_hi_nx = buf_hi;
        csum_nx   = csum;
        case (state)
            S_IDLE: begin
                if (start) begin
                    k_nx     = '0;
                    csum_nx  = '0;
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                // Both words are snapshotted here; later register writes cannot leak in.
                buf_lo_nx = rd1;
                buf_hi_nx = (FORCE_ZR && (k == K_LAST)) ? '0 : rd2;
                state_nx  = S_SEND_LO;
            end
            S_SEND_LO: begin
                if (out_ready) begin
                    csum_nx  = csum ^ buf_lo;
                    state_nx = S_SEND_HI;
                end
            end
            S_SEND_HI: begin
                if (out_ready) begin
                    csum_nx = csum ^ buf_hi;
                    if (k == K_LAST) begin
                        state_nx = S_DONE;
                    end else begin
                        k_nx     = k + 1'b1;
                        state_nx = S_FETCH;
                    end
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs decode only state, k and the buffers, so ready/rd never reach them combinationally.
    always_comb begin
        busy      = (state != S_IDLE);
        hold_wr   = (state != S_IDLE);
        done      = (state == S_DONE);
        out_valid = (state == S_SEND_LO) || (state == S_SEND_HI);
        ra1       = {k, 1'b0};
        ra2       = {k, 1'b1};
        out_idx   = {k, (state == S_SEND_HI)};
        checksum  = csum;
        case (state)
            S_SEND_LO: out_data = buf_lo;
            S_SEND_HI: out_data = buf_hi;
            default:   out_data = '0;
        endcase
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed and randomized checks of regfile_dump against a cycle timeline
// derived from the dump rules, with a behavioural register file alongside.
module tb_regfile_dump;
    import regfile_dump_pkg::*;

    localparam int DW   = 64;
    localparam int NR   = 32;
    localparam int AW   = 5;
    localparam int MAXC = 300;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b1;

    logic          busy_a, done_a, hold_a, ov_a;
    logic [AW-1:0] ra1_a, ra2_a, oi_a;
    logic [DW-1:0] rd1_a, rd2_a, od_a, ck_a;
    logic          busy_b, done_b, hold_b, ov_b;
    logic [AW-1:0] ra1_b, ra2_b, oi_b;
    logic [DW-1:0] rd1_b, rd2_b, od_b, ck_b;

    logic [DW-1:0] regs [NR];
    logic [DW-1:0] img  [NR];
    logic          load = 1'b0;
    logic          we3 = 1'b0;
    logic [AW-1:0] wa3 = '0;
    logic [DW-1:0] wd3 = '0;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic          rdy   [MAXC];
    logic          stp   [MAXC];
    logic          exp_v [MAXC];
    logic [AW-1:0] exp_i [MAXC];
    logic [DW-1:0] exp_a [MAXC];
    logic [DW-1:0] exp_b [MAXC];
    logic [DW-1:0] snap  [NR];
    logic [DW-1:0] got_a [NR];
    logic [DW-1:0] got_b [NR];
    logic [DW-1:0] exp_ck_a, exp_ck_b, part;
    int            done_at;
    int            obs_done;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < NR; i++) regs[i] <= img[i];
        end else if (we3 && !hold_a) begin
            regs[wa3] <= wd3;
        end
    end

    assign rd1_a = regs[ra1_a];
    assign rd2_a = regs[ra2_a];
    assign rd1_b = regs[ra1_b];
    assign rd2_b = regs[ra2_b];

    regfile_dump dut_a (
        .clk(clk), .reset(reset), .start(start), .busy(busy_a), .done(done_a),
        .hold_wr(hold_a), .ra1(ra1_a), .ra2(ra2_a), .rd1(rd1_a), .rd2(rd2_a),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_idx(oi_a),
        .checksum(ck_a)
    );

    regfile_dump #(.FORCE_ZR(1'b0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .busy(busy_b), .done(done_b),
        .hold_wr(hold_b), .ra1(ra1_b), .ra2(ra2_b), .rd1(rd1_b), .rd2(rd2_b),
        .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_idx(oi_b),
        .checksum(ck_b)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload();
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic clear_patterns();
        for (int c = 0; c < MAXC; c++) begin
            rdy[c] = 1'b1;
            stp[c] = 1'b0;
        end
    endtask

    // Cycle 0 presents start; each pair costs one fetch cycle, each word is
    // offered until a cycle with ready high; done follows the last acceptance.
    task automatic build_model();
        int n;
        for (int c = 0; c < MAXC; c++) begin
            exp_v[c] = 1'b0;
            exp_i[c] = '0;
            exp_a[c] = '0;
            exp_b[c] = '0;
        end
        exp_ck_a = '0;
        exp_ck_b = '0;
        n = 0;
        for (int w = 0; w < NR; w++) begin
            if (w % 2 == 0) n++;
            do begin
                n++;
                exp_v[n] = 1'b1;
                exp_i[n] = AW'(w);
                exp_a[n] = (w == NR - 1) ? '0 : snap[w];
                exp_b[n] = snap[w];
            end while (!rdy[n]);
            exp_ck_a ^= exp_a[n];
            exp_ck_b ^= exp_b[n];
        end
        done_at = n + 1;
    endtask

    task automatic run_dump(input bit writes, input int exp_done);
        for (int i = 0; i < NR; i++) begin
            snap[i]  = regs[i];
            got_a[i] = 'x;
            got_b[i] = 'x;
        end
        build_model();
        obs_done = -1;
        for (int n = 0; n <= done_at + 2; n++) begin
            start     = (n == 0) ? 1'b1 : stp[n];
            out_ready = rdy[n];
            if (writes && n >= 1 && n <= done_at) begin
                we3 = 1'b1;
                wa3 = AW'($urandom);
                wd3 = {$urandom, $urandom};
            end else begin
                we3 = 1'b0;
            end
            if (done_a === 1'b1) obs_done = n;
            chk("valid_a", DW'(ov_a), DW'(exp_v[n]));
            chk("valid_b", DW'(ov_b), DW'(exp_v[n]));
            chk("busy", DW'(busy_a), DW'(n >= 1 && n <= done_at));
            chk("hold_wr", DW'(hold_a), DW'(n >= 1 && n <= done_at));
            chk("done", DW'(done_a), DW'(n == done_at));
            if (exp_v[n]) begin
                chk("idx_a", DW'(oi_a), DW'(exp_i[n]));
                chk("data_a", od_a, exp_a[n]);
                chk("idx_b", DW'(oi_b), DW'(exp_i[n]));
                chk("data_b", od_b, exp_b[n]);
                if (rdy[n]) begin
                    got_a[exp_i[n]] = od_a;
                    got_b[exp_i[n]] = od_b;
                end
            end
            step();
        end
        start = 1'b0;
        we3   = 1'b0;
        out_ready = 1'b1;
        chk("checksum_a", ck_a, exp_ck_a);
        chk("checksum_b", ck_b, exp_ck_b);
        if (exp_done > 0) chk("done_cycle", DW'(obs_done), DW'(exp_done));
    endtask

    initial begin
        clear_patterns();
        step();
        step();
        chk("rst_busy", DW'(busy_a), '0);
        chk("rst_done", DW'(done_a), '0);
        chk("rst_hold", DW'(hold_a), '0);
        chk("rst_valid", DW'(ov_a), '0);
        chk("rst_data", od_a, '0);
        chk("rst_idx", DW'(oi_a), '0);
        chk("rst_csum", ck_a, '0);
        chk("rst_ra1", DW'(ra1_a), '0);
        chk("rst_ra2", DW'(ra2_a), DW'(1));
        reset = 1'b0;
        step();
        chk("idle_busy", DW'(busy_a), '0);

        // Identity preload with a zero top register.
        for (int i = 0; i < NR; i++) img[i] = DW'(i);
        img[NR-1] = '0;
        preload();
        run_dump(1'b0, 49);
        chk("t1_csum", ck_a, DW'(31));
        chk("t1_w30", got_a[30], DW'(30));
        chk("t1_w31", got_a[31], '0);

        // Top register non-zero: only the FORCE_ZR instance masks it.
        img[NR-1] = 64'hDEAD;
        preload();
        run_dump(1'b0, 49);
        chk("t2_zr_a", got_a[31], '0);
        chk("t2_zr_b", got_b[31], 64'hDEAD);
        chk("t2_csum_a", ck_a, DW'(31));
        chk("t2_csum_b", ck_b, DW'(31) ^ 64'hDEAD);

        // Five-cycle stall while index 7 is offered.
        for (int c = 12; c <= 16; c++) rdy[c] = 1'b0;
        run_dump(1'b0, 54);
        chk("t3_w7", got_a[7], DW'(7));
        clear_patterns();

        // Start pulses mid-dump must be ignored.
        stp[10] = 1'b1;
        stp[30] = 1'b1;
        run_dump(1'b0, 49);
        clear_patterns();

        // Reset in cycle 20 (index 12 being offered).
        for (int i = 0; i < NR; i++) img[i] = {$urandom, $urandom};
        preload();
        part = '0;
        for (int i = 0; i < 12; i++) part ^= img[i];
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (19) step();
        chk("pre_rst_valid", DW'(ov_a), DW'(1));
        chk("pre_rst_idx", DW'(oi_a), DW'(12));
        chk("pre_rst_csum", ck_a, part);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", DW'(ov_a), '0);
        chk("mid_rst_busy", DW'(busy_a), '0);
        chk("mid_rst_hold", DW'(hold_a), '0);
        chk("mid_rst_done", DW'(done_a), '0);
        chk("mid_rst_csum", ck_a, '0);
        chk("mid_rst_data", od_a, '0);
        chk("mid_rst_idx", DW'(oi_a), '0);
        chk("mid_rst_ra1", DW'(ra1_a), '0);
        step();
        reset = 1'b0;
        step();
        run_dump(1'b0, 49);
        chk("post_rst_w0", got_a[0], img[0]);

        // Writes gated by hold_wr during a dump, then a visible write afterwards.
        run_dump(1'b1, 49);
        for (int i = 0; i < NR; i++) chk("held_reg", regs[i], img[i]);
        we3 = 1'b1;
        wa3 = AW'(5);
        wd3 = 64'h5A5A_0000_1234_5678;
        step();
        we3 = 1'b0;
        run_dump(1'b0, 49);
        chk("w5_visible", got_a[5], 64'h5A5A_0000_1234_5678);

        // Random contents and random backpressure.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NR; i++) img[i] = {$urandom, $urandom};
            for (int c = 1; c < 200; c++) rdy[c] = ($urandom_range(0, 2) != 0);
            preload();
            run_dump(1'b1, 0);
            clear_patterns();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
